spi_slave_word: RTL and testbench

//  Parametrised full-duplex SPI slave: configurable word width and SPI mode (CPOL/CPHA),
//  any number of back-to-back words per frame. Received words are presented on a parallel

---
 rtl/spi_slave_word.sv | 171 +++++++++++++++++
 tb/tb_spi_slave_word.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_word.sv
// Full-duplex SPI slave with WIDTH-bit MSB-first words and any CPOL/CPHA; all pins synchronised into clk.
// Optional macro SPI_SLAVE_TX_UNDERRUN_EN adds a tx_underrun pulse output.
module spi_slave_word #(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_sck,
    input  logic             spi_ssel,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             busy
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    ,
    output logic             tx_underrun
`endif
);
    localparam int   CW             = $clog2(WIDTH);
    localparam logic SCK_IDLE       = (CPOL != 0);
    localparam logic SAMPLE_ON_RISE = (CPOL == CPHA);
    localparam logic CPHA1          = (CPHA != 0);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sck_sync, ssel_sync, mosi_sync;
    logic             sck_d, ssel_d;
    logic             sck_s, ssel_s, mosi_s;
    logic             sck_rise, sck_fall, ssel_fall;
    logic             sample_edge, shift_edge;
    logic             load, take, in_word;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] rx_shift, tx_shift, hold;
    logic             hold_full, skip_shift, done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
            ssel_sync <= '1;
            mosi_sync <= '0;
            sck_d     <= SCK_IDLE;
            ssel_d    <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], spi_ssel};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_d     <= sck_s;
            ssel_d    <= ssel_s;
        end
    end

    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign ssel_s      = ssel_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign sck_rise    = sck_s & ~sck_d;
    assign sck_fall    = ~sck_s & sck_d;
    assign ssel_fall   = ssel_d & ~ssel_s;
    assign sample_edge = SAMPLE_ON_RISE ? sck_rise : sck_fall;
    assign shift_edge  = SAMPLE_ON_RISE ? sck_fall : sck_rise;
    assign in_word     = (state == ACTIVE) && !ssel_s;
    assign take        = tx_valid && !hold_full;

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (ssel_fall) begin
                    state_nx = ACTIVE;
                    load     = 1'b1;
                end
            end
            ACTIVE: begin
                if (ssel_s)
                    state_nx = IDLE;
                else if (done)
                    load = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            skip_shift <= 1'b0;
            done       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
        end else begin
            state    <= state_nx;
            rx_valid <= done;
            done     <= 1'b0;
            if (done)
                rx_data <= rx_shift;

            if (take) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (load) begin
                tx_shift   <= hold_full ? hold : '0;
                bit_cnt    <= '0;
                // Mid-frame reloads (and CPHA=1) must let the next shift edge present the MSB, not advance past it.
                skip_shift <= CPHA1 || (state == ACTIVE);
            end else if (in_word) begin
                if (sample_edge) begin
                    rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
                    if (bit_cnt == CW'(WIDTH - 1)) begin
                        bit_cnt <= '0;
                        done    <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (shift_edge) begin
                    if (skip_shift)
                        skip_shift <= 1'b0;
                    else
                        tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                end
            end else begin
                bit_cnt <= '0;
            end
        end
    end

    assign busy        = (state == ACTIVE);
    assign spi_miso_oe = busy;
    assign spi_miso    = busy & tx_shift[WIDTH-1];
    assign tx_ready    = ~hold_full;

`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    // A zero-filled word is reported once it actually starts shifting, so the idle reload after a frame's last word is not an underrun.
    logic ur_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ur_pend     <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (load) begin
                ur_pend <= !hold_full;
            end else if (state_nx == IDLE) begin
                ur_pend <= 1'b0;
            end else if (sample_edge && ur_pend) begin
                ur_pend     <= 1'b0;
                tx_underrun <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word: a mode-0 8-bit slave and a mode-3 16-bit slave driven by a bit-level SPI master.
module tb_spi_slave_word;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          samp_cyc = 0;
    int          rxv_a_cyc = 0;
    int          n_rx_a = 0;
    int          n_rx_b = 0;

    logic        sck_a, ssel_a, mosi_a, miso_a, oe_a, rxv_a, txv_a, txr_a, busy_a;
    logic [7:0]  rxd_a, txd_a;
    logic        sck_b, ssel_b, mosi_b, miso_b, oe_b, rxv_b, txv_b, txr_b, busy_b;
    logic [15:0] rxd_b, txd_b;
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    logic        ur_a, ur_b;
    int          n_ur_a = 0;
    int          ur_base = 0;
`endif

    logic [15:0] exp_rx_a[$];
    logic [15:0] exp_rx_b[$];
    logic [15:0] txq_a[$];
    logic [15:0] txq_b[$];

    spi_slave_word #(.WIDTH(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .spi_sck(sck_a), .spi_ssel(ssel_a), .spi_mosi(mosi_a),
        .spi_miso(miso_a), .spi_miso_oe(oe_a), .rx_data(rxd_a), .rx_valid(rxv_a),
        .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(txr_a), .busy(busy_a)
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        , .tx_underrun(ur_a)
`endif
    );

    spi_slave_word #(.WIDTH(16), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .spi_sck(sck_b), .spi_ssel(ssel_b), .spi_mosi(mosi_b),
        .spi_miso(miso_b), .spi_miso_oe(oe_b), .rx_data(rxd_b), .rx_valid(rxv_b),
        .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(txr_b), .busy(busy_b)
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        , .tx_underrun(ur_b)
`endif
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Single compare process: every rx_valid cycle must match the next expected word.
    initial forever begin
        @(negedge clk);
        if (rxv_a) begin
            rxv_a_cyc = cyc;
            n_rx_a++;
            if (exp_rx_a.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rx_a_spurious: got %h with no word expected", rxd_a);
            end else begin
                check("rx_a_word", 32'(rxd_a), 32'(exp_rx_a.pop_front()));
            end
        end
        if (rxv_b) begin
            n_rx_b++;
            if (exp_rx_b.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rx_b_spurious: got %h with no word expected", rxd_b);
            end else begin
                check("rx_b_word", 32'(rxd_b), 32'(exp_rx_b.pop_front()));
            end
        end
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        if (ur_a)
            n_ur_a++;
`endif
    end

    // Transmit feeders: offer the queue head whenever non-empty; acceptance is decided by tx_ready before the next posedge.
    initial forever begin
        @(negedge clk);
        if (txq_a.size() > 0) begin
            txv_a = 1'b1;
            txd_a = txq_a[0][7:0];
            if (txr_a)
                void'(txq_a.pop_front());
        end else begin
            txv_a = 1'b0;
        end
        if (txq_b.size() > 0) begin
            txv_b = 1'b1;
            txd_b = txq_b[0];
            if (txr_b)
                void'(txq_b.pop_front());
        end else begin
            txv_b = 1'b0;
        end
    end

    // Master bit: A is mode 0 (set data, rise=sample, fall), B is mode 3 (fall=shift, rise=sample).
    task automatic send_bit(input bit b, input logic d, output logic m);
        if (!b) begin
            mosi_a = d;
            wait_clk(H);
            sck_a = 1'b1;
            m = miso_a;
            samp_cyc = cyc;
            wait_clk(H);
            sck_a = 1'b0;
        end else begin
            sck_b = 1'b0;
            mosi_b = d;
            wait_clk(H);
            sck_b = 1'b1;
            m = miso_b;
            samp_cyc = cyc;
            wait_clk(H);
        end
    endtask

    task automatic xfer(input bit b, input logic [15:0] w, input int width, input int nbits,
                        output logic [15:0] mw);
        logic m;
        mw = '0;
        for (int i = 0; i < nbits; i++) begin
            send_bit(b, w[width-1-i], m);
            mw = {mw[14:0], m};
        end
    endtask

    task automatic frame_start(input bit b);
        if (b) ssel_b = 1'b0; else ssel_a = 1'b0;
        wait_clk(H);
    endtask

    task automatic frame_end(input bit b);
        wait_clk(H);
        if (b) ssel_b = 1'b1; else ssel_a = 1'b1;
        wait_clk(3 * H);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_data"}, 32'(rxd_a), 32'h0);
        check({tag, "_rx_valid"}, 32'(rxv_a), 32'h0);
        check({tag, "_miso"}, 32'(miso_a), 32'h0);
        check({tag, "_miso_oe"}, 32'(oe_a), 32'h0);
        check({tag, "_busy"}, 32'(busy_a), 32'h0);
        check({tag, "_tx_ready"}, 32'(txr_a), 32'h1);
        check({tag, "_b_rx_data"}, 32'(rxd_b), 32'h0);
        check({tag, "_b_tx_ready"}, 32'(txr_b), 32'h1);
    endtask

    logic [15:0] mw;
    logic [15:0] words[3];
    int          base;

    initial begin
        sck_a = 1'b0; ssel_a = 1'b1; mosi_a = 1'b0; txv_a = 1'b0; txd_a = '0;
        sck_b = 1'b1; ssel_b = 1'b1; mosi_b = 1'b0; txv_b = 1'b0; txd_b = '0;
        wait_clk(3);
        check_reset_vals("rst0");
        rst_n = 1'b1;
        wait_clk(3);

        // 1: single word, preloaded transmit word
        txq_a.push_back(16'h00A5);
        wait_clk(3);
        check("t1_ready_full", 32'(txr_a), 32'h0);
        exp_rx_a.push_back(16'h00CC);
        frame_start(0);
        check("t1_busy", 32'(busy_a), 32'h1);
        check("t1_oe", 32'(oe_a), 32'h1);
        check("t1_ready_after_load", 32'(txr_a), 32'h1);
        xfer(0, 16'h00CC, 8, 8, mw);
        frame_end(0);
        check("t1_rx_data", 32'(rxd_a), 32'hCC);
        check("t1_miso", 32'(mw), 32'hA5);
        check("t1_latency", 32'(rxv_a_cyc - samp_cyc), 32'd4);
        check("t1_pulses", 32'(n_rx_a), 32'd1);
        check("t1_idle_busy", 32'(busy_a), 32'h0);

        // 2: three back-to-back words with transmit refill
        words[0] = 16'h11; words[1] = 16'h22; words[2] = 16'h33;
        for (int i = 0; i < 3; i++) txq_a.push_back(16'(i + 1));
        for (int i = 0; i < 3; i++) exp_rx_a.push_back(words[i]);
        wait_clk(3);
        base = n_rx_a;
        frame_start(0);
        for (int i = 0; i < 3; i++) begin
            xfer(0, words[i], 8, 8, mw);
            check("t2_miso", 32'(mw), 32'(i + 1));
        end
        frame_end(0);
        check("t2_pulses", 32'(n_rx_a - base), 32'd3);
        check("t2_rx_data", 32'(rxd_a), 32'h33);
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        check("t2_underrun", 32'(n_ur_a), 32'd0);
`endif

        // 3: aborted partial word, holding word survives, then full word
        txq_a.push_back(16'h11);
        txq_a.push_back(16'h96);
        wait_clk(3);
        base = n_rx_a;
        frame_start(0);
        xfer(0, 16'h00F0, 8, 5, mw);
        frame_end(0);
        check("t3_partial_miso", 32'(mw), 32'h02);
        check("t3_no_pulse", 32'(n_rx_a - base), 32'd0);
        check("t3_rx_held", 32'(rxd_a), 32'h33);
        check("t3_hold_kept", 32'(txr_a), 32'h0);
        exp_rx_a.push_back(16'h5A);
        frame_start(0);
        xfer(0, 16'h005A, 8, 8, mw);
        frame_end(0);
        check("t3_rx_data", 32'(rxd_a), 32'h5A);
        check("t3_miso", 32'(mw), 32'h96);

        // 4: 16-bit mode-3 slave
        txq_b.push_back(16'h1234);
        wait_clk(3);
        exp_rx_b.push_back(16'hBEEF);
        frame_start(1);
        xfer(1, 16'hBEEF, 16, 16, mw);
        frame_end(1);
        check("t4_rx_data", 32'(rxd_b), 32'hBEEF);
        check("t4_miso", 32'(mw), 32'h1234);
        check("t4_pulses", 32'(n_rx_b), 32'd1);

        // 5: transmit underrun over a two-word frame
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        ur_base = n_ur_a;
`endif
        exp_rx_a.push_back(16'h81);
        exp_rx_a.push_back(16'h7E);
        frame_start(0);
        xfer(0, 16'h0081, 8, 8, mw);
        check("t5_miso0", 32'(mw), 32'h0);
        xfer(0, 16'h007E, 8, 8, mw);
        check("t5_miso1", 32'(mw), 32'h0);
        frame_end(0);
        check("t5_rx_data", 32'(rxd_a), 32'h7E);
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        check("t5_underrun", 32'(n_ur_a - ur_base), 32'd2);
`endif

        // 6: reset in the middle of a word
        frame_start(0);
        xfer(0, 16'h00FF, 8, 3, mw);
        rst_n = 1'b0;
        wait_clk(2);
        check_reset_vals("rst_mid");
        ssel_a = 1'b1;
        sck_a = 1'b0;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
        exp_rx_a.push_back(16'h3C);
        frame_start(0);
        xfer(0, 16'h003C, 8, 8, mw);
        frame_end(0);
        check("t6_rx_data", 32'(rxd_a), 32'h3C);
        check("t6_tx_ready", 32'(txr_a), 32'h1);
        check("t6_miso", 32'(mw), 32'h0);

        check("end_rx_a_left", 32'(exp_rx_a.size()), 32'd0);
        check("end_rx_b_left", 32'(exp_rx_b.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
